memory_access: RTL and testbench
================================

Name: memory_access

Overview:
- Memory stage placed directly after the execute stage of the MIPS pipeline.
- Takes the execute result (effective address for LW/SW/LB/LBU/SB/SH, ALU result otherwise) and the store operand (rt).
- Runs a request/acknowledge transaction with a variable-latency data memory. Lane-selects and extends load data.
- Returns a write-back result with a single-cycle valid pulse and back-pressures the execute stage while busy.

Parameters:
- TIMEOUT_CYCLES, 255: max cycles in ACCESS without mem_ack before abort; range 1..255.
- DATA_W, 32: datapath width; only 32 supported.

Ports:
- clock  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-high
- valid_in  in  1  execute output valid
- ready_out  out  1  stage can accept; high only in IDLE
- insn  in  32 [0:31]  instruction; opcode = insn[0:5]
- addr_in  in  32 [0:31]  execute data_out (address or ALU result)
- store_data  in  32 [0:31]  rt value for stores
- mem_req  out  1  memory request, held until ack
- mem_we  out  1  1 = store
- mem_addr  out  32  word-aligned address (bits [30:31] forced 0)
- mem_wdata  out  32  lane-replicated store data
- mem_byte_en  out  4 [0:3]  lane enables; [0] = bits [0:7] (big-endian)
- mem_ack  in  1  one-cycle acknowledge; rdata valid same cycle
- mem_rdata  in  32  read word
- valid_out  out  1  one-cycle result pulse
- result  out  32  write-back value
- misalign_err  out  1  qualifies valid_out: misaligned access
- timeout_err  out  1  qualifies valid_out: no ack within TIMEOUT_CYCLES

Behaviour:
- Reset (async, any state): state=IDLE. ready_out=1 (combinational from IDLE). All other outputs = 0. Timeout counter = 0. In-flight transaction discarded; no valid_out for it.
- Accept: valid_in && ready_out at a rising edge; latch insn, addr_in, store_data.
- States and transitions:
  - IDLE. Non-memory opcode accepted: next edge valid_out=1, result=addr_in, stay IDLE (1-cycle latency, no stall). Memory opcode, aligned: go to ACCESS with mem_req=1 from next cycle. Memory opcode, misaligned: valid_out=1, misalign_err=1, result=addr_in, no request, stay IDLE.
  - ACCESS. mem_req=1; mem_we, mem_addr, mem_wdata, mem_byte_en stable throughout. mem_ack sampled high: next cycle mem_req=0, valid_out=1, result set, go to IDLE. Ack absent: counter++. On the edge where counter reaches TIMEOUT_CYCLES: mem_req=0, valid_out=1, timeout_err=1, result=0, go to IDLE.
- Memory opcodes: LW 100011, SW 101011, LB 100000, LBU 100100, SB 101000, SH 101001.
- Alignment: LW/SW need addr[30:31]=00. SH needs addr[31]=0. Bytes are always aligned.
- Lane k = addr[30:31] selects bits [8k:8k+7].
- LB: sign-extend selected byte. LBU: zero-extend. LW: full word.
- SB: byte_en one-hot at lane k; wdata = store_data[24:31] replicated ×4.
- SH: byte_en 1100 (addr[30]=0) or 0011; wdata = store_data[16:31] ×2.
- SW: byte_en 1111.
- Loads drive byte_en 1111, mem_we=0.
- Stores: result=0 on completion.
- valid_out, misalign_err and timeout_err are exactly one cycle wide and never overlap with mem_req rising.
- mem_ack while not in ACCESS is ignored.
- valid_in while ready_out=0: not accepted; upstream must hold.
- Back-to-back: a transaction may be accepted in the same cycle valid_out pulses (IDLE re-entered).

Test Plan:
- Non-memory: insn opcode 000000, addr_in=0x0000_002A, valid_in 1 cycle -> next cycle valid_out=1, result=0x2A, mem_req never asserted.
- LB sign/LBU zero: mem_rdata=0x1280_FF34. LB at addr 0x103 (lane 3) -> result 0x0000_0034. LB at 0x102 -> 0xFFFF_FFFF. LBU at 0x102 -> 0x0000_00FF. mem_addr=0x100 in every case.
- SH/SB lanes: store_data=0xAABB_CCDD. SH at 0x202 -> byte_en 0011, wdata 0xCCDD_CCDD. SB at 0x201 -> byte_en 0100, wdata 0xDDDD_DDDD, mem_we=1.
- Multi-cycle ack: LW 0x400, ack after 5 cycles with rdata 0xDEAD_BEEF -> mem_req held 5 cycles, ready_out=0 throughout, valid_out one cycle after ack, result 0xDEAD_BEEF.
- Misalign and timeout:
  - SW at 0x402 -> misalign_err=1 with valid_out next cycle, no mem_req.
  - With TIMEOUT_CYCLES=4, LW with no ack -> timeout_err pulse after 4 ACCESS cycles, mem_req dropped.
- Reset mid-ACCESS: assert reset asynchronously while mem_req=1 -> mem_req=0 immediately, ready_out=1, later ack ignored, no valid_out.

Source files
------------

// File: rtl/memory_access.sv
// memory_access
//   MIPS memory stage sitting directly behind execute. Accepts the execute
//   result (effective address or ALU value) plus the rt store operand. It runs
//   a req/ack transaction against a variable-latency data memory, lane-selects
//   and extends load data, and returns a one-cycle write-back pulse.
//
// Ports
//   clock, reset          : single rising-edge clock, async active-high reset
//   valid_in / ready_out  : execute handshake; ready_out is high only in IDLE
//   insn                  : instruction word, opcode in insn[0:5] (big-endian)
//   addr_in               : address for memory ops, ALU result otherwise
//   store_data            : rt operand for SB/SH/SW
//   mem_req .. mem_byte_en: request to data memory, stable while in ACCESS
//   mem_ack, mem_rdata    : one-cycle acknowledge with read data
//   valid_out, result     : one-cycle write-back pulse and value
//   misalign_err          : qualifies valid_out, access was misaligned
//   timeout_err           : qualifies valid_out, memory never acknowledged
module memory_access #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned DATA_W         = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              valid_in,
  output logic              ready_out,
  input  logic [0:31]       insn,
  input  logic [0:DATA_W-1] addr_in,
  input  logic [0:DATA_W-1] store_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [0:DATA_W-1] mem_addr,
  output logic [0:DATA_W-1] mem_wdata,
  output logic [0:3]        mem_byte_en,
  input  logic              mem_ack,
  input  logic [0:DATA_W-1] mem_rdata,
  output logic              valid_out,
  output logic [0:DATA_W-1] result,
  output logic              misalign_err,
  output logic              timeout_err
);

  localparam logic [0:5] OP_LW  = 6'b100011;
  localparam logic [0:5] OP_SW  = 6'b101011;
  localparam logic [0:5] OP_LB  = 6'b100000;
  localparam logic [0:5] OP_LBU = 6'b100100;
  localparam logic [0:5] OP_SB  = 6'b101000;
  localparam logic [0:5] OP_SH  = 6'b101001;

  localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYCLES);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t            state_q, state_d;
  logic [7:0]        count_q, count_d;
  logic [0:5]        op_q, op_d;
  logic [1:0]        lane_q, lane_d;
  logic              mem_we_q, mem_we_d;
  logic [0:DATA_W-1] mem_addr_q, mem_addr_d;
  logic [0:DATA_W-1] mem_wdata_q, mem_wdata_d;
  logic [0:3]        mem_byte_en_q, mem_byte_en_d;
  logic              valid_out_q, valid_out_d;
  logic [0:DATA_W-1] result_q, result_d;
  logic              misalign_q, misalign_d;
  logic              timeout_q, timeout_d;

  logic [0:5]        opcode;
  logic [1:0]        acc_lane;
  logic              acc_is_mem;
  logic              acc_is_store;
  logic              acc_misaligned;
  logic [0:3]        acc_be;
  logic [0:DATA_W-1] acc_wdata;
  logic [0:7]        ld_byte;
  logic [0:DATA_W-1] load_result;
  logic [7:0]        count_inc;
  logic              unused_insn;

  assign opcode      = insn[0:5];
  assign acc_lane    = addr_in[30:31];
  assign count_inc   = count_q + 8'd1;
  assign unused_insn = ^insn[6:31];

  // Decode the incoming instruction: memory-op class, alignment, lane enables
  // and lane-replicated store data so the memory sees the operand on every lane.
  always_comb begin
    acc_is_mem     = 1'b0;
    acc_is_store   = 1'b0;
    acc_misaligned = 1'b0;
    acc_be         = 4'b1111;
    acc_wdata      = store_data;
    case (opcode)
      OP_LW: begin
        acc_is_mem     = 1'b1;
        acc_misaligned = |acc_lane;
      end
      OP_SW: begin
        acc_is_mem     = 1'b1;
        acc_is_store   = 1'b1;
        acc_misaligned = |acc_lane;
      end
      OP_LB, OP_LBU: begin
        acc_is_mem = 1'b1;
      end
      OP_SB: begin
        acc_is_mem   = 1'b1;
        acc_is_store = 1'b1;
        acc_be       = 4'b1000 >> acc_lane;
        acc_wdata    = {4{store_data[24:31]}};
      end
      OP_SH: begin
        acc_is_mem     = 1'b1;
        acc_is_store   = 1'b1;
        acc_misaligned = acc_lane[0];
        acc_be         = acc_lane[1] ? 4'b0011 : 4'b1100;
        acc_wdata      = {2{store_data[16:31]}};
      end
      default: ;
    endcase
  end

  // Pick the addressed byte of the returned word (lane 0 is the MSB) and
  // extend it according to the latched opcode; stores write back zero.
  always_comb begin
    case (lane_q)
      2'd0:    ld_byte = mem_rdata[0:7];
      2'd1:    ld_byte = mem_rdata[8:15];
      2'd2:    ld_byte = mem_rdata[16:23];
      default: ld_byte = mem_rdata[24:31];
    endcase
    case (op_q)
      OP_LW:   load_result = mem_rdata;
      OP_LB:   load_result = {{24{ld_byte[0]}}, ld_byte};
      OP_LBU:  load_result = {24'h000000, ld_byte};
      default: load_result = '0;
    endcase
  end

  // Next-state and output logic. Result pulses are registered so they appear
  // the cycle after the accepting edge or the ack/timeout edge.
  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    op_d          = op_q;
    lane_d        = lane_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    mem_byte_en_d = mem_byte_en_q;
    valid_out_d   = 1'b0;
    misalign_d    = 1'b0;
    timeout_d     = 1'b0;
    result_d      = result_q;
    case (state_q)
      IDLE: begin
        if (valid_in) begin
          if (!acc_is_mem) begin
            valid_out_d = 1'b1;
            result_d    = addr_in;
          end else if (acc_misaligned) begin
            valid_out_d = 1'b1;
            misalign_d  = 1'b1;
            result_d    = addr_in;
          end else begin
            state_d       = ACCESS;
            count_d       = 8'd0;
            op_d          = opcode;
            lane_d        = acc_lane;
            mem_we_d      = acc_is_store;
            mem_addr_d    = {addr_in[0:29], 2'b00};
            mem_wdata_d   = acc_wdata;
            mem_byte_en_d = acc_be;
          end
        end
      end
      ACCESS: begin
        if (mem_ack || (count_inc == TIMEOUT_LIM)) begin
          // Ack wins over a timeout landing on the same edge.
          state_d       = IDLE;
          count_d       = 8'd0;
          valid_out_d   = 1'b1;
          timeout_d     = !mem_ack;
          result_d      = mem_ack ? load_result : '0;
          mem_we_d      = 1'b0;
          mem_addr_d    = '0;
          mem_wdata_d   = '0;
          mem_byte_en_d = 4'b0000;
        end else begin
          count_d = count_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset drops any transaction in flight without a pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      count_q       <= 8'd0;
      op_q          <= 6'b000000;
      lane_q        <= 2'd0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      mem_byte_en_q <= 4'b0000;
      valid_out_q   <= 1'b0;
      result_q      <= '0;
      misalign_q    <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      op_q          <= op_d;
      lane_q        <= lane_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_byte_en_q <= mem_byte_en_d;
      valid_out_q   <= valid_out_d;
      result_q      <= result_d;
      misalign_q    <= misalign_d;
      timeout_q     <= timeout_d;
    end
  end

  assign ready_out    = (state_q == IDLE);
  assign mem_req      = (state_q == ACCESS);
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign mem_byte_en  = mem_byte_en_q;
  assign valid_out    = valid_out_q;
  assign result       = result_q;
  assign misalign_err = misalign_q;
  assign timeout_err  = timeout_q;

endmodule

// File: tb/tb_memory_access.sv
// tb_memory_access
//   Self-checking bench for memory_access. The main instance uses the default
//   timeout; a second instance with TIMEOUT_CYCLES=4 exercises the abort path.
//   Expected write-back values are queued when stimulus is driven and popped
//   when the DUT pulses valid_out.
module tb_memory_access;

  typedef struct packed {
    logic [31:0] result;
    logic        mis;
    logic        to;
  } exp_t;

  localparam logic [5:0] OP_ALU = 6'b000000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;

  exp_t sb[$];
  int   tests_run    = 0;
  int   tests_failed = 0;

  logic        clock      = 1'b0;
  logic        reset      = 1'b1;
  logic        valid_in   = 1'b0;
  logic        valid_in2  = 1'b0;
  logic        mem_ack    = 1'b0;
  logic        mem_ack2   = 1'b0;
  logic [0:31] insn       = '0;
  logic [0:31] addr_in    = '0;
  logic [0:31] store_data = '0;
  logic [0:31] mem_rdata  = '0;

  logic        ready_out, mem_req, mem_we, valid_out, misalign_err, timeout_err;
  logic [0:31] mem_addr, mem_wdata, result;
  logic [0:3]  mem_byte_en;

  logic        ready_out2, mem_req2, mem_we2, valid_out2, misalign_err2, timeout_err2;
  logic [0:31] mem_addr2, mem_wdata2, result2;
  logic [0:3]  mem_byte_en2;

  memory_access dut (
    .clock(clock), .reset(reset), .valid_in(valid_in), .ready_out(ready_out),
    .insn(insn), .addr_in(addr_in), .store_data(store_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_byte_en(mem_byte_en),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .valid_out(valid_out), .result(result),
    .misalign_err(misalign_err), .timeout_err(timeout_err)
  );

  memory_access #(.TIMEOUT_CYCLES(4)) dut_to (
    .clock(clock), .reset(reset), .valid_in(valid_in2), .ready_out(ready_out2),
    .insn(insn), .addr_in(addr_in), .store_data(store_data),
    .mem_req(mem_req2), .mem_we(mem_we2), .mem_addr(mem_addr2),
    .mem_wdata(mem_wdata2), .mem_byte_en(mem_byte_en2),
    .mem_ack(mem_ack2), .mem_rdata(mem_rdata),
    .valid_out(valid_out2), .result(result2),
    .misalign_err(misalign_err2), .timeout_err(timeout_err2)
  );

  initial forever #5 clock = ~clock;

  // Advance to 1 ns past the next rising edge, where inputs are driven and
  // outputs are sampled.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [5:0] op, input logic [31:0] a, input logic [31:0] sd);
    insn       = {op, 26'h0};
    addr_in    = a;
    store_data = sd;
    valid_in   = 1'b1;
    tick();
    valid_in   = 1'b0;
  endtask

  // Plays the memory: waits `delay` request cycles, then acks with rdata.
  // Captures the request fields and whether they stayed stable and busy.
  task automatic serve(input int delay, input logic [31:0] rdata,
                       output int req_cycles, output logic [31:0] cap_addr,
                       output logic [31:0] cap_wdata, output logic [3:0] cap_be,
                       output logic cap_we, output bit stable_ok, output bit got_valid);
    cap_addr   = mem_addr;
    cap_wdata  = mem_wdata;
    cap_be     = mem_byte_en;
    cap_we     = mem_we;
    req_cycles = 0;
    stable_ok  = 1'b1;
    for (int i = 0; i < delay; i++) begin
      if (mem_req) req_cycles++;
      if (ready_out || valid_out || mem_addr !== cap_addr || mem_wdata !== cap_wdata ||
          mem_byte_en !== cap_be || mem_we !== cap_we) stable_ok = 1'b0;
      if (i == delay - 1) begin
        mem_ack   = 1'b1;
        mem_rdata = rdata;
      end
      tick();
    end
    mem_ack   = 1'b0;
    got_valid = valid_out;
  endtask

  task automatic test_reset();
    tests_run++;
    if (ready_out !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL reset_ready: got %b expected 1", ready_out);
    end
    tests_run++;
    if ({mem_req, mem_we, valid_out, misalign_err, timeout_err} !== 5'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_ctrl: got %b expected 00000",
               {mem_req, mem_we, valid_out, misalign_err, timeout_err});
    end
    tests_run++;
    if ({mem_addr, mem_wdata, mem_byte_en, result} !== 100'h0) begin
      tests_failed++;
      $display("[TB] FAIL reset_data: got %h expected 0", {mem_addr, mem_wdata, mem_byte_en, result});
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_non_mem();
    exp_t e;
    int   reqs = 0;
    sb.push_back('{32'h0000_002A, 1'b0, 1'b0});
    insn = {OP_ALU, 26'h0}; addr_in = 32'h0000_002A; valid_in = 1'b1;
    if (mem_req) reqs++;
    tick();
    valid_in = 1'b0;
    if (mem_req) reqs++;
    tests_run++;
    if (valid_out !== 1'b1 || ready_out !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL alu_latency: got valid=%b ready=%b expected 1 1", valid_out, ready_out);
    end
    if (valid_out === 1'b1) begin
      e = sb.pop_front();
      tests_run++;
      if ({result, misalign_err, timeout_err} !== {e.result, e.mis, e.to}) begin
        tests_failed++;
        $display("[TB] FAIL alu_result: got %h expected %h", result, e.result);
      end
    end
    tick();
    if (mem_req) reqs++;
    tests_run++;
    if (reqs != 0 || valid_out !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL alu_no_req: got reqs=%0d valid=%b expected 0 0", reqs, valid_out);
    end
  endtask

  task automatic test_load_lanes();
    logic [5:0]  ops[3]   = '{OP_LB, OP_LB, OP_LBU};
    logic [31:0] addrs[3] = '{32'h103, 32'h102, 32'h102};
    logic [31:0] exps[3]  = '{32'h0000_0034, 32'hFFFF_FFFF, 32'h0000_00FF};
    exp_t e;
    int req_c; logic [31:0] ca, cw; logic [3:0] cb; logic cwe; bit st, gv;
    for (int i = 0; i < 3; i++) begin
      sb.push_back('{exps[i], 1'b0, 1'b0});
      send(ops[i], addrs[i], 32'h0);
      serve(1, 32'h1280_FF34, req_c, ca, cw, cb, cwe, st, gv);
      tests_run++;
      if (ca !== 32'h100 || cb !== 4'b1111 || cwe !== 1'b0 || req_c != 1) begin
        tests_failed++;
        $display("[TB] FAIL load_req[%0d]: got addr=%h be=%b we=%b req=%0d expected 100 1111 0 1",
                 i, ca, cb, cwe, req_c);
      end
      tests_run++;
      if (!gv) begin
        tests_failed++;
        $display("[TB] FAIL load_valid[%0d]: got 0 expected 1", i);
      end else begin
        e = sb.pop_front();
        if ({result, misalign_err, timeout_err} !== {e.result, e.mis, e.to}) begin
          tests_failed++;
          $display("[TB] FAIL load_result[%0d]: got %h expected %h", i, result, e.result);
        end
      end
      tick();
    end
  endtask

  task automatic test_store_lanes();
    logic [5:0]  ops[2]   = '{OP_SH, OP_SB};
    logic [31:0] addrs[2] = '{32'h202, 32'h201};
    logic [3:0]  bes[2]   = '{4'b0011, 4'b0100};
    logic [31:0] wds[2]   = '{32'hCCDD_CCDD, 32'hDDDD_DDDD};
    exp_t e;
    int req_c; logic [31:0] ca, cw; logic [3:0] cb; logic cwe; bit st, gv;
    for (int i = 0; i < 2; i++) begin
      sb.push_back('{32'h0, 1'b0, 1'b0});
      send(ops[i], addrs[i], 32'hAABB_CCDD);
      serve(2, 32'h5555_5555, req_c, ca, cw, cb, cwe, st, gv);
      tests_run++;
      if (cb !== bes[i] || cw !== wds[i] || cwe !== 1'b1 || ca !== 32'h200 || !st) begin
        tests_failed++;
        $display("[TB] FAIL store_req[%0d]: got be=%b wdata=%h we=%b addr=%h stable=%b expected %b %h 1 200 1",
                 i, cb, cw, cwe, ca, st, bes[i], wds[i]);
      end
      tests_run++;
      if (!gv) begin
        tests_failed++;
        $display("[TB] FAIL store_valid[%0d]: got 0 expected 1", i);
      end else begin
        e = sb.pop_front();
        if ({result, misalign_err, timeout_err} !== {e.result, e.mis, e.to}) begin
          tests_failed++;
          $display("[TB] FAIL store_result[%0d]: got %h expected %h", i, result, e.result);
        end
      end
      tick();
    end
  endtask

  task automatic test_multi_cycle();
    exp_t e;
    int req_c; logic [31:0] ca, cw; logic [3:0] cb; logic cwe; bit st, gv;
    sb.push_back('{32'hDEAD_BEEF, 1'b0, 1'b0});
    send(OP_LW, 32'h400, 32'h0);
    serve(5, 32'hDEAD_BEEF, req_c, ca, cw, cb, cwe, st, gv);
    tests_run++;
    if (req_c != 5 || !st || mem_req !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL lw_hold: got req=%0d busy_stable=%b req_after=%b expected 5 1 0",
               req_c, st, mem_req);
    end
    tests_run++;
    if (!gv) begin
      tests_failed++;
      $display("[TB] FAIL lw_valid: got 0 expected 1");
    end else begin
      e = sb.pop_front();
      if ({result, misalign_err, timeout_err} !== {e.result, e.mis, e.to}) begin
        tests_failed++;
        $display("[TB] FAIL lw_result: got %h expected %h", result, e.result);
      end
    end
    tick();
    tests_run++;
    if (valid_out !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL lw_pulse_width: got %b expected 0", valid_out);
    end
  endtask

  task automatic test_misalign();
    logic [5:0]  ops[3]   = '{OP_SW, OP_SH, OP_LW};
    logic [31:0] addrs[3] = '{32'h402, 32'h201, 32'h401};
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      sb.push_back('{addrs[i], 1'b1, 1'b0});
      send(ops[i], addrs[i], 32'h1234_5678);
      tests_run++;
      if (valid_out !== 1'b1 || mem_req !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL misalign_pulse[%0d]: got valid=%b req=%b expected 1 0", i, valid_out, mem_req);
      end else begin
        e = sb.pop_front();
        if ({result, misalign_err, timeout_err} !== {e.result, e.mis, e.to}) begin
          tests_failed++;
          $display("[TB] FAIL misalign_result[%0d]: got %h/%b/%b expected %h/1/0",
                   i, result, misalign_err, timeout_err, e.result);
        end
      end
      tick();
    end
  endtask

  task automatic test_timeout();
    exp_t e;
    int reqs = 0;
    bit seen = 1'b0;
    sb.push_back('{32'h0, 1'b0, 1'b1});
    insn = {OP_LW, 26'h0}; addr_in = 32'h500; valid_in2 = 1'b1;
    tick();
    valid_in2 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (valid_out2) begin
        seen = 1'b1;
        break;
      end
      if (mem_req2) reqs++;
      tick();
    end
    tests_run++;
    if (!seen || reqs != 4 || mem_req2 !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL timeout_abort: got seen=%b req_cycles=%0d expected 1 4", seen, reqs);
    end else begin
      e = sb.pop_front();
      if ({result2, misalign_err2, timeout_err2} !== {e.result, e.mis, e.to}) begin
        tests_failed++;
        $display("[TB] FAIL timeout_result: got %h/%b/%b expected %h/0/1",
                 result2, misalign_err2, timeout_err2, e.result);
      end
    end
    tick();
    tests_run++;
    if (valid_out2 !== 1'b0 || timeout_err2 !== 1'b0 || ready_out2 !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL timeout_width: got valid=%b to=%b ready=%b expected 0 0 1",
               valid_out2, timeout_err2, ready_out2);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int req_c; logic [31:0] ca, cw; logic [3:0] cb; logic cwe; bit st, gv;
    sb.push_back('{32'h0000_0011, 1'b0, 1'b0});
    insn = {OP_ALU, 26'h0}; addr_in = 32'h11; valid_in = 1'b1;
    tick();
    tests_run++;
    if (valid_out !== 1'b1 || ready_out !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL b2b_first: got valid=%b ready=%b expected 1 1", valid_out, ready_out);
    end else begin
      e = sb.pop_front();
      if (result !== e.result) begin
        tests_failed++;
        $display("[TB] FAIL b2b_first_result: got %h expected %h", result, e.result);
      end
    end
    sb.push_back('{32'hCAFE_F00D, 1'b0, 1'b0});
    insn = {OP_LW, 26'h0}; addr_in = 32'h600;
    tick();
    valid_in = 1'b0;
    tests_run++;
    if (mem_req !== 1'b1 || valid_out !== 1'b0 || mem_addr !== 32'h600) begin
      tests_failed++;
      $display("[TB] FAIL b2b_accept: got req=%b valid=%b addr=%h expected 1 0 600", mem_req, valid_out, mem_addr);
    end
    serve(2, 32'hCAFE_F00D, req_c, ca, cw, cb, cwe, st, gv);
    tests_run++;
    if (!gv) begin
      tests_failed++;
      $display("[TB] FAIL b2b_second_valid: got 0 expected 1");
    end else begin
      e = sb.pop_front();
      if (result !== e.result) begin
        tests_failed++;
        $display("[TB] FAIL b2b_second_result: got %h expected %h", result, e.result);
      end
    end
    tick();
  endtask

  task automatic test_reset_mid();
    bit spurious = 1'b0;
    send(OP_LW, 32'h700, 32'h0);
    tests_run++;
    if (mem_req !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL rst_mid_req: got %b expected 1", mem_req);
    end
    #2 reset = 1'b1;
    #1;
    tests_run++;
    if (mem_req !== 1'b0 || ready_out !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL rst_mid_async: got req=%b ready=%b expected 0 1", mem_req, ready_out);
    end
    #1 reset = 1'b0;
    mem_ack   = 1'b1;
    mem_rdata = 32'h0BAD_0BAD;
    tick();
    mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (valid_out !== 1'b0 || mem_req !== 1'b0) spurious = 1'b1;
      tick();
    end
    tests_run++;
    if (spurious) begin
      tests_failed++;
      $display("[TB] FAIL rst_mid_ignore_ack: got spurious activity expected none");
    end
    tests_run++;
    if (sb.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
    end
  endtask

  initial begin
    #22;
    test_reset();
    test_non_mem();
    test_load_lanes();
    test_store_lanes();
    test_multi_cycle();
    test_misalign();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
